// File: rtl/fuzz_pkg.sv
// ---------------------------------------------------------------------------
// fuzz_pkg
// Shared types for the fuzz target responder.
//   resp_state_t : responder FSM state (normal operation / hung-core fault)
//   TAG_W, tag_t : width and type of the per-request sequence tag
// ---------------------------------------------------------------------------
package fuzz_pkg;

    typedef enum logic {ST_RUN, ST_FAULT} resp_state_t;

    localparam int TAG_W = 8;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/fuzz_sync_fifo.sv
// ---------------------------------------------------------------------------
// fuzz_sync_fifo
// Single-clock FIFO with a registered head output (no fall-through: a word
// pushed into an empty FIFO appears on dout the cycle after the push).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      synchronous discard of all stored entries
//   push, din  write strobe and data (ignored when full or flushing)
//   pop        read strobe (ignored when empty); dout advances next cycle
//   dout       current head entry, valid while !empty
//   full, empty, count   occupancy status
// ---------------------------------------------------------------------------
module fuzz_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = dout_reg;

    assign do_push     = push && !full && !flush;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = do_pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    // Storage array kept free of reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
            // Registered head read. The write slot only equals the next head
            // slot when the FIFO is about to hold exactly this one word, so
            // forward din in that case instead of reading the stale array.
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                dout_reg <= din;
            end else begin
                dout_reg <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/fuzz_target_responder.sv
// ---------------------------------------------------------------------------
// fuzz_target_responder
// Responder side of the fuzzer start/data handshake. Accepted requests are
// issued to a fixed-latency, non-stallable core; core results are tagged with
// the launch tag and returned in order through a response FIFO. A credit
// check bounds outstanding work to the FIFO depth; a watchdog declares FAULT
// when the core goes silent, and stray core results are flagged.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_start, req_data         request strobe/payload; req_ready = can accept
//   core_start, core_data       one-cycle issue pulse and payload to the core
//   core_out, core_out_valid    core result and strobe
//   rsp_valid/rsp_data/rsp_tag  response head; consumed with rsp_ready
//   clear_fault                 leave FAULT (once drained) / clear err_spurious
//   err_timeout, err_spurious   sticky error flags
//   req_count, rsp_count        16-bit wrapping activity counters
// ---------------------------------------------------------------------------
module fuzz_target_responder
    import fuzz_pkg::*;
#(
    parameter int INPUT_WIDTH  = 256,
    parameter int OUTPUT_WIDTH = 128,
    parameter int RSP_DEPTH    = 8,
    parameter int CORE_TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_start,
    input  logic [INPUT_WIDTH-1:0]  req_data,
    output logic                    req_ready,
    output logic                    core_start,
    output logic [INPUT_WIDTH-1:0]  core_data,
    input  logic [OUTPUT_WIDTH-1:0] core_out,
    input  logic                    core_out_valid,
    output logic                    rsp_valid,
    output logic [OUTPUT_WIDTH-1:0] rsp_data,
    output logic [7:0]              rsp_tag,
    input  logic                    rsp_ready,
    input  logic                    clear_fault,
    output logic                    err_timeout,
    output logic                    err_spurious,
    output logic [15:0]             req_count,
    output logic [15:0]             rsp_count
);

    localparam int CNT_W   = $clog2(RSP_DEPTH) + 1;
    localparam int TIMER_W = $clog2(CORE_TIMEOUT) + 1;
    localparam int RSP_W   = TAG_W + OUTPUT_WIDTH;

    resp_state_t            state_reg;
    tag_t                   tag_reg;
    logic [TIMER_W-1:0]     timer_reg;
    logic                   core_start_reg;
    logic [INPUT_WIDTH-1:0] core_data_reg;
    logic                   err_timeout_reg;
    logic                   err_spurious_reg;
    logic [15:0]            req_count_reg;
    logic [15:0]            rsp_count_reg;

    // The tag FIFO holds one entry per request that has been accepted but
    // whose core result has not yet arrived, so its occupancy is the
    // in-flight count.
    tag_t             tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic [CNT_W-1:0] inflight;

    logic [RSP_W-1:0] rsp_head;
    logic             rsp_full;
    logic             rsp_empty;
    logic [CNT_W-1:0] fifo_count;

    logic [CNT_W:0]   outstanding;
    logic             accept;
    logic             core_hit;
    logic             spurious;
    logic             rsp_push;
    logic             rsp_pop;
    logic             timeout_hit;

    // Credits are taken at accept time, so a result can never find the
    // response FIFO full.
    assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
    assign req_ready   = !rst && (state_reg == ST_RUN) && !tag_full &&
                         (outstanding < (CNT_W+1)'(RSP_DEPTH));
    assign accept      = req_start && req_ready;

    assign core_hit    = core_out_valid && !tag_empty;
    assign spurious    = core_out_valid && tag_empty;
    assign rsp_push    = core_hit && !rsp_full;
    assign rsp_pop     = !rsp_empty && rsp_ready;

    assign timeout_hit = (state_reg == ST_RUN) && !core_out_valid && !tag_empty &&
                         (timer_reg == TIMER_W'(CORE_TIMEOUT - 1));

    fuzz_sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (RSP_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (timeout_hit),
        .push  (accept),
        .din   (tag_reg),
        .pop   (core_hit),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (inflight)
    );

    fuzz_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (rsp_push),
        .din   ({tag_head, core_out}),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            tag_reg          <= '0;
            timer_reg        <= '0;
            core_start_reg   <= 1'b0;
            core_data_reg    <= '0;
            err_timeout_reg  <= 1'b0;
            err_spurious_reg <= 1'b0;
            req_count_reg    <= '0;
            rsp_count_reg    <= '0;
        end else begin
            core_start_reg <= accept;
            if (accept) begin
                core_data_reg <= req_data;
                tag_reg       <= tag_reg + tag_t'(1);
                req_count_reg <= req_count_reg + 16'd1;
            end
            if (rsp_pop) begin
                rsp_count_reg <= rsp_count_reg + 16'd1;
            end

            // Watchdog only runs while work is outstanding and the core is quiet.
            if (core_out_valid || tag_empty || timeout_hit) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + TIMER_W'(1);
            end

            case (state_reg)
                ST_RUN: begin
                    if (clear_fault) begin
                        err_spurious_reg <= 1'b0;
                    end
                    if (timeout_hit) begin
                        state_reg       <= ST_FAULT;
                        err_timeout_reg <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Recovery waits for the consumer to drain what the core
                    // did deliver before the hang.
                    if (clear_fault && rsp_empty) begin
                        state_reg        <= ST_RUN;
                        err_timeout_reg  <= 1'b0;
                        err_spurious_reg <= 1'b0;
                    end
                end
            endcase

            // A fresh stray result outranks a same-cycle clear.
            if (spurious) begin
                err_spurious_reg <= 1'b1;
            end
        end
    end

    assign core_start   = core_start_reg;
    assign core_data    = core_data_reg;
    assign rsp_valid    = !rsp_empty;
    assign rsp_tag      = rsp_head[RSP_W-1 -: TAG_W];
    assign rsp_data     = rsp_head[OUTPUT_WIDTH-1:0];
    assign err_timeout  = err_timeout_reg;
    assign err_spurious = err_spurious_reg;
    assign req_count    = req_count_reg;
    assign rsp_count    = rsp_count_reg;

endmodule

// File: tb/tb_fuzz_target_responder.sv
// ---------------------------------------------------------------------------
// tb_fuzz_target_responder
// Self-checking bench. A behavioural core (fixed latency, result = state^key)
// answers core_start; a queue of expected {tag, result} pairs built from the
// accepted requests predicts every response, and req_ready is predicted from
// the number of accepted-but-undelivered requests.
// ---------------------------------------------------------------------------
module tb_fuzz_target_responder;

    localparam int IW    = 256;
    localparam int OW    = 128;
    localparam int DEPTH = 8;
    localparam int TMO   = 1000;
    localparam int LAT   = 10;

    typedef struct packed {
        logic [7:0]    tag;
        logic [OW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_start;
    logic [IW-1:0] req_data;
    logic          req_ready;
    logic          core_start;
    logic [IW-1:0] core_data;
    logic [OW-1:0] core_out;
    logic          core_out_valid;
    logic          rsp_valid;
    logic [OW-1:0] rsp_data;
    logic [7:0]    rsp_tag;
    logic          rsp_ready;
    logic          clear_fault;
    logic          err_timeout;
    logic          err_spurious;
    logic [15:0]   req_count;
    logic [15:0]   rsp_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   next_tag = 0;

    // Core model controls
    bit            core_stuck = 1'b0;
    bit            inject     = 1'b0;
    int            cyc        = 0;
    logic          sched_v [64];
    logic [OW-1:0] sched_d [64];

    fuzz_target_responder #(
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW),
        .RSP_DEPTH    (DEPTH),
        .CORE_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_start      (req_start),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .core_start     (core_start),
        .core_data      (core_data),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .rsp_ready      (rsp_ready),
        .clear_fault    (clear_fault),
        .err_timeout    (err_timeout),
        .err_spurious   (err_spurious),
        .req_count      (req_count),
        .rsp_count      (rsp_count)
    );

    always #5 clk = ~clk;

    // Behavioural core: answers LAT cycles after it sees core_start.
    initial begin
        for (int i = 0; i < 64; i++) begin
            sched_v[i] = 1'b0;
            sched_d[i] = '0;
        end
        core_out_valid = 1'b0;
        core_out       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            core_out_valid = sched_v[cyc % 64] | inject;
            core_out       = sched_v[cyc % 64] ? sched_d[cyc % 64] : OW'($urandom);
            sched_v[cyc % 64] = 1'b0;
            inject = 1'b0;
            if (core_start && !core_stuck) begin
                sched_v[(cyc + LAT) % 64] = 1'b1;
                sched_d[(cyc + LAT) % 64] = core_data[127:0] ^ core_data[255:128];
            end
        end
    end

    function automatic logic [IW-1:0] rand_payload();
        logic [IW-1:0] v;
        for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Advance one cycle: sample req_ready, drive inputs, report handshakes.
    task automatic cycle(input bit start, input bit rdy, output bit acc, output bit pop, output bit rr);
        @(negedge clk);
        rr        = req_ready;
        req_start = start;
        req_data  = rand_payload();
        rsp_ready = rdy;
        acc       = start && rr;
        pop       = rsp_valid && rdy;
    endtask

    // Model: an accepted request yields {its tag, state ^ key}.
    task automatic model_accept();
        exp_q.push_back('{tag: 8'(next_tag), data: req_data[127:0] ^ req_data[255:128]});
        next_tag++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_start = 1'b0; rsp_ready = 1'b0; clear_fault = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        next_tag = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_start = 1'b0; req_data = '0; rsp_ready = 1'b0; clear_fault = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++;
        if ({core_start, core_data, rsp_valid, rsp_data, rsp_tag, err_timeout, err_spurious, req_count, rsp_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got start=%b valid=%b tag=%0h errs=%b%b cnt=%0d/%0d exp=all zero",
                     core_start, rsp_valid, rsp_tag, err_timeout, err_spurious, req_count, rsp_count);
        end
        rst = 1'b0;
        exp_q.delete();
        next_tag = 0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
        $display("reset: outputs idle, req_ready=%b after release", req_ready);
    endtask

    task automatic test_single();
        bit acc, pop, rr, early;
        logic [IW-1:0] d;
        cycle(1'b1, 1'b1, acc, pop, rr);
        d = req_data;
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", acc); end
        if (acc) model_accept();
        cycle(1'b0, 1'b1, acc, pop, rr);
        checks++;
        if (core_start !== 1'b1 || core_data !== d) begin
            errors++; $display("FAIL single_issue got start=%b data=%h exp start=1 data=%h", core_start, core_data, d);
        end
        early = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            cycle(1'b0, 1'b1, acc, pop, rr);
            if (k == 2) begin
                checks++;
                if (core_start !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b exp=0", core_start); end
            end
            if (k < 12 && rsp_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL single_early_valid got=1 exp=0 before cycle 12"); end
        checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL single_valid_at_12 got=%b exp=1", rsp_valid);
        end else begin
            checks++;
            if (rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data) begin
                errors++; $display("FAIL single_rsp got tag=%0d data=%h exp tag=%0d data=%h", rsp_tag, rsp_data, exp_q[0].tag, exp_q[0].data);
            end
            $display("single: tag=%0d data=%h", rsp_tag, rsp_data);
            void'(exp_q.pop_front());
        end
        cycle(1'b0, 1'b1, acc, pop, rr);
        checks++;
        if (req_count !== 16'd1 || rsp_count !== 16'd1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_counts got req=%0d rsp=%0d valid=%b exp 1/1/0", req_count, rsp_count, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit acc, pop, rr;
        int nacc, ndel, guard;
        do_reset();
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, acc, pop, rr);
            checks++;
            if (rr !== (exp_q.size() < DEPTH)) begin
                errors++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, rr, exp_q.size() < DEPTH);
            end
            if (acc) begin model_accept(); nacc++; end
        end
        cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (nacc != 8 || rr !== 1'b0) begin
            errors++; $display("FAIL b2b_accepted got=%0d ready=%b exp=8 ready=0", nacc, rr);
        end
        repeat (15) cycle(1'b0, 1'b0, acc, pop, rr);
        ndel = 0;
        guard = 0;
        while (ndel < 8 && guard < 40) begin
            cycle(1'b0, 1'b1, acc, pop, rr);
            guard++;
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_rsp got tag=%0d exp=none", rsp_tag);
                end else begin
                    if (rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data) begin
                        errors++; $display("FAIL b2b_rsp got tag=%0d data=%h exp tag=%0d data=%h", rsp_tag, rsp_data, exp_q[0].tag, exp_q[0].data);
                    end
                    void'(exp_q.pop_front());
                end
                $display("b2b: tag=%0d", rsp_tag);
                ndel++;
            end
        end
        checks++;
        if (ndel != 8) begin errors++; $display("FAIL b2b_drain got=%0d exp=8", ndel); end
    endtask

    task automatic test_random_stream();
        bit acc, pop, rr;
        int nacc, ndel, guard;
        do_reset();
        nacc = 0; ndel = 0; guard = 0;
        while ((nacc < 300 || ndel < 300) && guard < 5000) begin
            cycle((nacc < 300) && ($urandom_range(3) != 0), $urandom_range(1) == 1, acc, pop, rr);
            guard++;
            checks++;
            if (rr !== (exp_q.size() < DEPTH)) begin
                errors++; $display("FAIL stream_ready got=%b exp=%b outstanding=%0d", rr, exp_q.size() < DEPTH, exp_q.size());
            end
            if (acc) begin model_accept(); nacc++; end
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_rsp got tag=%0d exp=none", rsp_tag);
                end else begin
                    if (rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data) begin
                        errors++; $display("FAIL stream_rsp got tag=%0d data=%h exp tag=%0d data=%h", rsp_tag, rsp_data, exp_q[0].tag, exp_q[0].data);
                    end
                    void'(exp_q.pop_front());
                end
                $display("stream: rsp %0d tag=%0d", ndel, rsp_tag);
                ndel++;
            end
        end
        cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (req_count !== 16'd300 || rsp_count !== 16'd300 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stream_counts got req=%0d rsp=%0d valid=%b exp 300/300/0", req_count, rsp_count, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        bit acc, pop, rr;
        do_reset();
        // One good response left queued so clear_fault is first refused.
        cycle(1'b1, 1'b0, acc, pop, rr);
        if (acc) model_accept();
        repeat (14) cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL timeout_queued got=%b exp=1", rsp_valid); end
        core_stuck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, acc, pop, rr);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL timeout_issue[%0d] got=%b exp=1", i, acc); end
            next_tag++;   // these requests are lost to the hang
        end
        repeat (998) cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0 at silent cycle %0d", err_timeout, TMO - 1); end
        cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (err_timeout !== 1'b1 || rr !== 1'b0) begin
            errors++; $display("FAIL timeout_fault got err=%b ready=%b exp err=1 ready=0", err_timeout, rr);
        end
        clear_fault = 1'b1;
        cycle(1'b0, 1'b0, acc, pop, rr);
        clear_fault = 1'b0;
        checks++;
        if (err_timeout !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL timeout_clear_nonempty got err=%b ready=%b exp err=1 ready=0", err_timeout, req_ready);
        end
        cycle(1'b0, 1'b1, acc, pop, rr);
        checks++;
        if (!pop || exp_q.size() == 0) begin
            errors++; $display("FAIL timeout_drain got valid=%b exp=1", rsp_valid);
        end else begin
            if (rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data) begin
                errors++; $display("FAIL timeout_drain_rsp got tag=%0d exp tag=%0d", rsp_tag, exp_q[0].tag);
            end
            void'(exp_q.pop_front());
        end
        cycle(1'b0, 1'b0, acc, pop, rr);
        clear_fault = 1'b1;
        cycle(1'b0, 1'b0, acc, pop, rr);
        clear_fault = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_recover got err=%b ready=%b exp err=0 ready=1", err_timeout, req_ready);
        end
        core_stuck = 1'b0;
        // The lost tags must have been discarded: next response carries tag 4.
        cycle(1'b1, 1'b1, acc, pop, rr);
        if (acc) model_accept();
        repeat (12) cycle(1'b0, 1'b1, acc, pop, rr);
        checks++;
        if (!pop || exp_q.size() == 0) begin
            errors++; $display("FAIL timeout_after_valid got valid=%b exp=1", rsp_valid);
        end else begin
            if (rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data) begin
                errors++; $display("FAIL timeout_after_rsp got tag=%0d data=%h exp tag=%0d data=%h", rsp_tag, rsp_data, exp_q[0].tag, exp_q[0].data);
            end
            void'(exp_q.pop_front());
        end
        $display("timeout: fault raised, recovered, next tag=%0d", rsp_tag);
        cycle(1'b0, 1'b0, acc, pop, rr);
    endtask

    task automatic test_spurious();
        bit acc, pop, rr;
        int nacc, ndel, guard;
        @(posedge clk);
        #1 inject = 1'b1;
        cycle(1'b0, 1'b0, acc, pop, rr);
        cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (err_spurious !== 1'b1 || rsp_valid !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL spurious_flag got err=%b valid=%b tmo=%b exp 1/0/0", err_spurious, rsp_valid, err_timeout);
        end
        // Credits must be intact: exactly DEPTH requests fit.
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, acc, pop, rr);
            if (acc) begin model_accept(); nacc++; end
        end
        checks++;
        if (nacc != DEPTH) begin errors++; $display("FAIL spurious_credits got=%0d exp=%0d", nacc, DEPTH); end
        ndel = 0; guard = 0;
        while (ndel < nacc && guard < 60) begin
            cycle(1'b0, 1'b1, acc, pop, rr);
            guard++;
            if (pop) begin
                checks++;
                if (exp_q.size() == 0 || rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data) begin
                    errors++; $display("FAIL spurious_rsp got tag=%0d exp tag=%0d", rsp_tag, exp_q.size() ? exp_q[0].tag : 8'hxx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                $display("spurious: tag=%0d", rsp_tag);
                ndel++;
            end
        end
        clear_fault = 1'b1;
        cycle(1'b0, 1'b0, acc, pop, rr);
        clear_fault = 1'b0;
        cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (err_spurious !== 1'b0 || ndel != nacc) begin
            errors++; $display("FAIL spurious_clear got err=%b delivered=%0d exp err=0 delivered=%0d", err_spurious, ndel, nacc);
        end
    endtask

    task automatic test_reset_mid();
        bit acc, pop, rr, leak;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, acc, pop, rr);
        repeat (8) cycle(1'b0, 1'b0, acc, pop, rr);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL resetmid_setup got=%b exp=1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, core_start, core_data, rsp_valid, rsp_data, rsp_tag, err_timeout, err_spurious, req_count, rsp_count} !== '0) begin
            errors++;
            $display("FAIL resetmid_outputs got ready=%b valid=%b tag=%0h cnt=%0d/%0d exp=all zero",
                     req_ready, rsp_valid, rsp_tag, req_count, rsp_count);
        end
        rst = 1'b0;
        exp_q.delete();
        next_tag = 0;
        leak = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b1, acc, pop, rr);
            if (rsp_valid !== 1'b0) leak = 1'b1;
        end
        checks++;
        if (leak || err_spurious !== 1'b1 || rsp_count !== 16'd0) begin
            errors++; $display("FAIL resetmid_late got leak=%b err=%b rsp=%0d exp leak=0 err=1 rsp=0", leak, err_spurious, rsp_count);
        end
        $display("reset_mid: state cleared, late core outputs flagged");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random_stream();
        test_timeout();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
